// File: rtl/xor_circular_decoder.sv
// xor_circular_decoder: receive-side decoder for the 2-bit-key circular XOR
// scrambler. It latches a per-frame key and decodes a stream of 4-bit words
// into a registered output stage. It also recomputes NZCV per word and counts
// flag mismatches.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Valid is never withdrawn by the producer side of this block (out_valid
// holds until out_ready), and the payload is stable while valid && !ready.
module xor_circular_decoder #(
  parameter int MAX_FRAME = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [1:0]           key,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_y,
  input  logic [3:0]           in_flags,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_b,
  output logic                 out_flag_err,
  output logic                 out_last,
  output logic                 frame_ovf,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  // Counter value before the increment that makes this word number MAX_FRAME.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_key;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out_valid;
  logic [3:0]             r_out_b;
  logic                   r_out_flag_err;
  logic                   r_out_last;
  logic                   r_frame_ovf;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_at_max;
  logic                   w_frame_end;
  logic [3:0]             w_b;
  logic [3:0]             w_flags;
  logic                   w_flag_err;

  // Ready is combinational from out_ready, so a draining output never
  // inserts a bubble.
  assign w_in_ready  = (r_state == S_ACTIVE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_at_max    = (r_cnt == LAST_IDX);
  assign w_frame_end = w_accept && (in_last || w_at_max);

  // Key bit 0 scrambles the even positions and key bit 1 the odd ones.
  assign w_b        = {in_y[3] ^ r_key[1], in_y[2] ^ r_key[0],
                       in_y[1] ^ r_key[1], in_y[0] ^ r_key[0]};
  assign w_flags    = {in_y[3], (in_y == 4'd0), r_key[1], r_key[1] ^ w_b[3]};
  assign w_flag_err = (w_flags != in_flags);

  // Next-state: the key starts a frame, and in_last or a full frame ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (key_valid)   w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_frame_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Key capture and per-frame word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= 2'b00;
      r_cnt <= '0;
    end else if (r_state == S_IDLE && key_valid) begin
      r_key <= key;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output register: load on accept, clear valid once consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_b        <= 4'd0;
      r_out_flag_err <= 1'b0;
      r_out_last     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_b        <= w_b;
      r_out_flag_err <= w_flag_err;
      r_out_last     <= in_last || w_at_max;
    end else if (out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  // Sticky overflow: the frame filled up without the source marking its end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_frame_ovf <= 1'b0;
    else if (w_accept && w_at_max && !in_last) r_frame_ovf <= 1'b1;
  end

  // Saturating flag-mismatch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_err_cnt <= '0;
    else if (w_accept && w_flag_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_b        = r_out_b;
  assign out_flag_err = r_out_flag_err;
  assign out_last     = r_out_last;
  assign frame_ovf    = r_frame_ovf;
  assign err_cnt      = r_err_cnt;
  assign busy         = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_xor_circular_decoder.sv
// Bench for xor_circular_decoder: directed steps followed by a random phase.
// Expected words come from a queue filled by a frame-level model.
module tb_xor_circular_decoder;

  localparam int MAX_FRAME = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       key_valid, in_valid, in_last, out_ready;
  logic [1:0] key;
  logic [3:0] in_y, in_flags;
  logic       in_ready, out_valid, out_flag_err, out_last, frame_ovf, busy;
  logic [3:0] out_b;
  logic [7:0] err_cnt;
  logic       in_ready2, out_valid2, out_flag_err2, out_last2, frame_ovf2, busy2;
  logic [3:0] out_b2;
  logic [1:0] err_cnt2;

  xor_circular_decoder #(.MAX_FRAME(MAX_FRAME), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_flags(in_flags),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_b(out_b), .out_flag_err(out_flag_err), .out_last(out_last),
    .frame_ovf(frame_ovf), .err_cnt(err_cnt), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  xor_circular_decoder #(.MAX_FRAME(MAX_FRAME), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key),
    .in_valid(in_valid), .in_ready(in_ready2), .in_y(in_y), .in_flags(in_flags),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_b(out_b2), .out_flag_err(out_flag_err2), .out_last(out_last2),
    .frame_ovf(frame_ovf2), .err_cnt(err_cnt2), .busy(busy2)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];   // {b, flag_err, last} of words not yet consumed
  bit   m_active;
  logic [1:0] m_key;
  int   m_cnt, m_err, n_deliv;
  bit   m_ovf, last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags_of(input logic [1:0] a, input logic [3:0] y);
    logic [3:0] b;
    b = y ^ {a, a};
    return {y[3], (y == 4'd0), a[1], a[1] ^ b[3]};
  endfunction

  // One clock: check outputs at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    bit exp_ready, was_active, end_w, at_max, err;
    logic [3:0] b;
    @(negedge clk);
    last_acc = 0;
    if (!rst_n) begin
      exp_q.delete(); m_active = 0; m_ovf = 0; m_err = 0; m_cnt = 0;
    end
    exp_ready = m_active && (exp_q.size() == 0 || out_ready);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("busy", busy, m_active);
    chk("frame_ovf", frame_ovf, m_ovf);
    chk("err_cnt", err_cnt, (m_err > 255) ? 255 : m_err);
    chk("err_cnt_w2", err_cnt2, (m_err > 3) ? 3 : m_err);
    if (exp_q.size() != 0) chk("out_word", {out_b, out_flag_err, out_last}, exp_q[0]);
    if (rst_n) begin
      was_active = m_active;
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        n_deliv++;
      end
      if (in_valid && exp_ready) begin
        b = in_y ^ {m_key, m_key};
        err = (flags_of(m_key, in_y) != in_flags);
        m_cnt++;
        at_max = (m_cnt == MAX_FRAME);
        end_w = in_last || at_max;
        exp_q.push_back({b, err, end_w});
        if (err) m_err++;
        if (end_w) m_active = 0;
        if (at_max && !in_last) m_ovf = 1;
        last_acc = 1;
      end
      if (!was_active && key_valid) begin
        m_active = 1; m_key = key; m_cnt = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_key(input logic [1:0] k);
    key_valid = 1'b1; key = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] y, input logic [3:0] f, input logic l);
    int n = 0;
    in_valid = 1'b1; in_y = y; in_flags = f; in_last = l;
    do begin tick(); n++; end while (!last_acc && n < 50);
    if (!last_acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] y;
    rst_n = 1'b0; key_valid = 0; key = 0; in_valid = 0; in_y = 0;
    in_flags = 0; in_last = 0; out_ready = 0;
    m_active = 0; m_key = 0; m_cnt = 0; m_err = 0; m_ovf = 0; n_deliv = 0;
    #3;
    chk("rst_out_b", out_b, 4'd0);
    chk("rst_out_flag_err", out_flag_err, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: key 10, single-word frame.
    out_ready = 1'b1;
    send_key(2'b10);
    send_word(4'b1011, 4'b1011, 1'b1);
    chk("t1_out_b", out_b, 4'b0001);
    chk("t1_err", out_flag_err, 1'b0);
    chk("t1_last", out_last, 1'b1);
    chk("t1_idle", busy, 1'b0);
    tick();

    // Test 2: zero word, matching then mismatching flags.
    send_key(2'b01);
    send_word(4'b0000, 4'b0100, 1'b0);
    chk("t2_out_b", out_b, 4'b0101);
    chk("t2_err0", out_flag_err, 1'b0);
    send_word(4'b0000, 4'b0000, 1'b1);
    chk("t2_err1", out_flag_err, 1'b1);
    chk("t2_err_cnt", err_cnt, 8'd1);
    tick();

    // Test 3: backpressure for 3 cycles after the first accept.
    send_key(2'b11);
    n_deliv = 0;
    out_ready = 1'b0;
    send_word(4'h3, flags_of(2'b11, 4'h3), 1'b0);
    in_valid = 1'b1; in_y = 4'hC; in_flags = flags_of(2'b11, 4'hC); in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_no_accept", last_acc, 1'b0);
      chk("t3_hold_b", out_b, 4'h3 ^ 4'hF);
    end
    out_ready = 1'b1;
    send_word(4'hC, flags_of(2'b11, 4'hC), 1'b0);
    send_word(4'h0, 4'h0, 1'b0);
    send_word(4'h9, flags_of(2'b11, 4'h9), 1'b1);
    tick(); tick();
    chk("t3_delivered", n_deliv, 4);

    // Test 4: overflow with key 00.
    send_key(2'b00);
    for (int i = 0; i < MAX_FRAME; i++) begin
      y = 4'($urandom_range(0, 15));
      send_word(y, flags_of(2'b00, y), 1'b0);
    end
    chk("t4_last", out_last, 1'b1);
    chk("t4_ovf", frame_ovf, 1'b1);
    chk("t4_busy", busy, 1'b0);
    in_valid = 1'b1; in_y = 4'h5; in_flags = flags_of(2'b00, 4'h5); in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_blocked", last_acc, 1'b0);
    end
    send_key(2'b01);
    send_word(4'h5, flags_of(2'b01, 4'h5), 1'b1);
    tick();

    // Test 5: reset mid-frame with a held word.
    send_key(2'b10);
    for (int i = 0; i < 3; i++) send_word(4'(i + 1), 4'hF, 1'b0);
    out_ready = 1'b0;
    tick();
    chk("t5_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_err_cnt", err_cnt, 8'd0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_in_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Test 6: five mismatched words saturate the 2-bit counter.
    send_key(2'b01);
    for (int i = 0; i < 5; i++) send_word(4'(i), ~flags_of(2'b01, 4'(i)), (i == 4));
    chk("t6_sat", err_cnt2, 2'b11);
    chk("t6_wide", err_cnt, 8'd5);
    tick();

    // Random phase.
    for (int c = 0; c < 800; c++) begin
      key_valid = (!m_active && $urandom_range(0, 3) == 0);
      key       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_y      = 4'($urandom_range(0, 15));
      in_flags  = ($urandom_range(0, 1) == 1) ? flags_of(m_key, in_y) : 4'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    key_valid = 0; in_valid = 0; out_ready = 1'b1;
    tick(); tick();
    chk("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
